lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DATA_W, 32, data word width.
- ADDR_W, 32, byte address width.
- RD_LAT, 2, data RAM read latency in cycles (address-register stage plus output-register stage).
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, pipeline access request.
- req_ready, out, 1, unit can accept a request.
- req_op, in, 4, access opcode.
- req_addr, in, ADDR_W, byte address.
- req_wdata, in, DATA_W, store data, right-aligned.
- resp_valid, out, 1, one-cycle completion pulse.
- resp_rdata, out, DATA_W, formatted load result; 0 for stores and errors.
- resp_err, out, 1, misaligned access, qualified by resp_valid.
- ram_ce, out, 1, RAM chip enable.
- ram_we, out, 1, RAM write enable.
- ram_addr, out, ADDR_W, RAM byte address.
- ram_sel, out, 4, RAM byte-lane enables.
- ram_wdata, out, DATA_W, RAM write data.
- ram_rdata, in, DATA_W, RAM registered read data.
REQ-003 Opcodes SHALL be: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=10. req_op[3]=1 denotes a store. Any other opcode SHALL be treated as misaligned (resp_err=1).

Function
REQ-004 The FSM SHALL have the states IDLE, WR, RD and RESP. req_ready SHALL be 1 only in IDLE. A request is accepted on any edge with req_valid && req_ready.
REQ-005 Misalignment SHALL be defined as: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. A misaligned request SHALL go IDLE->RESP with ram_ce=0, resp_err=1 and resp_rdata=0.
REQ-006 An aligned store SHALL go IDLE->WR, stay in WR for exactly 1 cycle with ram_ce=1 and ram_we=1, then go to RESP.
REQ-007 An aligned load SHALL go IDLE->RD and hold RD for RD_LAT+1 cycles with ram_ce=1, ram_we=0, and ram_addr/ram_sel stable. ram_rdata SHALL be sampled on the edge that closes the last RD cycle, then the FSM goes to RESP.
REQ-008 RESP SHALL last exactly 1 cycle with resp_valid=1, then return to IDLE. Accept-to-resp_valid latency SHALL be 1 cycle for misaligned requests, 2 for stores, and RD_LAT+2 for loads.
REQ-009 Byte lanes SHALL be big-endian:
- Byte at offset k uses ram_sel bit 3-k and data bits [31-8k -: 8].
- Halfword at offset 0 uses sel 1100, bits 31:16.
- Halfword at offset 2 uses sel 0011, bits 15:0.
- Word uses sel 1111.
REQ-010 Store data SHALL be replicated: SB drives {4{wdata[7:0]}}, SH drives {2{wdata[15:0]}}, SW drives wdata.
REQ-011 Loads SHALL extract the selected lane and right-align it. LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend.
REQ-012 ram_ce, ram_we, ram_addr, ram_sel and ram_wdata SHALL be registered, and SHALL be 0 in IDLE and RESP.
REQ-013 ram_rdata SHALL be ignored outside the sampling edge defined in REQ-007.

Reset
REQ-014 rst_n low SHALL asynchronously force the state to IDLE and clear the RD counter.
REQ-015 rst_n low SHALL asynchronously clear all registered outputs to 0 (ram_ce=0, ram_we=0, resp_valid=0, resp_err=0, resp_rdata=0, ram_addr/ram_sel/ram_wdata=0). req_ready SHALL be 1 once in IDLE.
REQ-016 A reset asserted mid-WR or mid-RD SHALL abort the access with no resp_valid. The RAM SHALL see ram_we drop to 0 in the same cycle.

Structure
REQ-017 The shared package lsu_pkg SHALL hold the opcode constants, the state enum, and the sel encodings.
REQ-018 One combinational sub-module, lsu_load_fmt, SHALL perform lane extraction and sign/zero extension. The FSM, RD counter and output registers SHALL stay in lsu_ctrl.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- SW addr 0x10, data 0xDEADBEEF: one WR cycle with sel=1111 and wdata=0xDEADBEEF; resp_valid 2 cycles after accept.
- SB addr 0x11, data 0x000000A5: sel=0100, wdata=0xA5A5A5A5. Then LB addr 0x11 returns 0xFFFFFFA5 and LBU addr 0x11 returns 0x000000A5, each at RD_LAT+2 cycles.
- Memory word 0x8001_7FFF: LH addr 0 returns 0xFFFF8001, LHU addr 0 returns 0x00008001, LH addr 2 returns 0x00007FFF.
- LW addr 0x13 and SH addr 0x21: no ram_ce pulse; resp_valid with resp_err=1 and resp_rdata=0 one cycle after accept.
- req_valid held high continuously: req_ready is low from accept through RESP; no second accept before IDLE; back-to-back throughput is one access per RD_LAT+3 cycles for loads.
- rst_n pulsed low during the second RD cycle: ram_ce=0 immediately, no resp_valid, req_ready=1 after release; the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, FSM states,
// byte-lane select encodings and request decode helpers.
package lsu_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  // Big-endian lanes: byte offset k maps to sel bit 3-k.
  localparam logic [3:0] SEL_NONE  = 4'b0000;
  localparam logic [3:0] SEL_BYTE0 = 4'b1000;
  localparam logic [3:0] SEL_HALF0 = 4'b1100;
  localparam logic [3:0] SEL_HALF2 = 4'b0011;
  localparam logic [3:0] SEL_WORD  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RESP
  } lsu_state_e;

  function automatic logic op_is_err(input logic [3:0] op, input logic [1:0] off);
    logic r;
    case (op)
      OP_LB, OP_LBU, OP_SB: r = 1'b0;
      OP_LH, OP_LHU, OP_SH: r = off[0];
      OP_LW, OP_SW:         r = (off != 2'b00);
      default:              r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] r;
    case (size)
      2'd0:    r = SEL_BYTE0 >> off;
      2'd1:    r = off[1] ? SEL_HALF2 : SEL_HALF0;
      default: r = SEL_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load result formatter: picks the addressed big-endian lane out of the
// RAM word and right-aligns it with sign or zero extension.
module lsu_load_fmt
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        i_op,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[DATA_W-1  -: 8];
      2'd1:    w_byte = i_rdata[DATA_W-9  -: 8];
      2'd2:    w_byte = i_rdata[DATA_W-17 -: 8];
      default: w_byte = i_rdata[DATA_W-25 -: 8];
    endcase
    w_half = i_off[1] ? i_rdata[DATA_W-17 -: 16] : i_rdata[DATA_W-1 -: 16];
  end

  always_comb begin
    o_data = '0;
    case (i_op)
      OP_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
      OP_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      OP_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
      OP_LW:   o_data = i_rdata;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one access at a time, drives a
// registered-read data RAM and returns a single-cycle response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

  lsu_state_e        r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [3:0]        r_op, w_op_next;
  logic [1:0]        r_off, w_off_next;
  logic              r_ram_ce, w_ram_ce_next;
  logic              r_ram_we, w_ram_we_next;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
  logic [3:0]        r_ram_sel, w_ram_sel_next;
  logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_next;
  logic              r_resp_valid, w_resp_valid_next;
  logic              r_resp_err, w_resp_err_next;
  logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_next;
  logic [DATA_W-1:0] w_store_data;
  logic [DATA_W-1:0] w_load_data;

  lsu_load_fmt #(.DATA_W(DATA_W)) u_fmt (
    .i_op    (r_op),
    .i_off   (r_off),
    .i_rdata (ram_rdata),
    .o_data  (w_load_data)
  );

  // Narrow stores are replicated so every enabled lane carries the data.
  always_comb begin
    case (req_op[1:0])
      2'd0:    w_store_data = {(DATA_W/8){req_wdata[7:0]}};
      2'd1:    w_store_data = {(DATA_W/16){req_wdata[15:0]}};
      default: w_store_data = req_wdata;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_op_next         = r_op;
    w_off_next        = r_off;
    w_ram_ce_next     = 1'b0;
    w_ram_we_next     = 1'b0;
    w_ram_addr_next   = '0;
    w_ram_sel_next    = SEL_NONE;
    w_ram_wdata_next  = '0;
    w_resp_valid_next = 1'b0;
    w_resp_err_next   = 1'b0;
    w_resp_rdata_next = '0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (req_valid) begin
          w_op_next  = req_op;
          w_off_next = req_addr[1:0];
          if (op_is_err(req_op, req_addr[1:0])) begin
            w_state_next      = ST_RESP;
            w_resp_valid_next = 1'b1;
            w_resp_err_next   = 1'b1;
          end else begin
            w_ram_ce_next   = 1'b1;
            w_ram_addr_next = req_addr;
            w_ram_sel_next  = lane_sel(req_op[1:0], req_addr[1:0]);
            if (req_op[3]) begin
              w_state_next     = ST_WR;
              w_ram_we_next    = 1'b1;
              w_ram_wdata_next = w_store_data;
            end else begin
              w_state_next = ST_RD;
            end
          end
        end
      end
      ST_WR: begin
        w_state_next      = ST_RESP;
        w_resp_valid_next = 1'b1;
      end
      ST_RD: begin
        // Address and lanes are held steady for the whole RAM read window.
        if (r_cnt == CNT_LAST) begin
          w_state_next      = ST_RESP;
          w_resp_valid_next = 1'b1;
          w_resp_rdata_next = w_load_data;
          w_cnt_next        = '0;
        end else begin
          w_ram_ce_next   = 1'b1;
          w_ram_addr_next = r_ram_addr;
          w_ram_sel_next  = r_ram_sel;
          w_cnt_next      = r_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_op         <= '0;
      r_off        <= '0;
      r_ram_ce     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_sel    <= '0;
      r_ram_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_op         <= w_op_next;
      r_off        <= w_off_next;
      r_ram_ce     <= w_ram_ce_next;
      r_ram_we     <= w_ram_we_next;
      r_ram_addr   <= w_ram_addr_next;
      r_ram_sel    <= w_ram_sel_next;
      r_ram_wdata  <= w_ram_wdata_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_err   <= w_resp_err_next;
      r_resp_rdata <= w_resp_rdata_next;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign ram_ce     = r_ram_ce;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_sel    = r_ram_sel;
  assign ram_wdata  = r_ram_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a two-stage registered-read RAM model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, ram_ce, ram_we;
  logic [31:0] resp_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  int n_cmp = 0;
  int n_bad = 0;

  int          t_lat, t_ce, t_we;
  logic [3:0]  t_sel;
  logic [31:0] t_wd, t_rd, t_ad;
  logic        t_err, t_busy_ok, t_addr_ok;

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [31:0] mem [0:63];
  logic [5:0]  ram_a_q;
  always @(posedge clk) begin
    if (ram_ce && ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_sel[i]) mem[ram_addr[7:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_a_q   <= ram_addr[7:2];
    ram_rdata <= mem[ram_a_q];
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    t_lat = 0; t_ce = 0; t_we = 0; t_sel = 0; t_wd = 0; t_rd = 0; t_ad = 0;
    t_err = 0; t_busy_ok = 1; t_addr_ok = 1;
    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    for (int n = 1; n <= 20; n++) begin
      if (req_ready) t_busy_ok = 0;
      if (ram_ce) begin
        t_ce++;
        if (ram_we) t_we++;
        if (t_ce == 1) begin
          t_sel = ram_sel; t_wd = ram_wdata; t_ad = ram_addr;
        end else if (ram_addr !== t_ad || ram_sel !== t_sel) t_addr_ok = 0;
      end
      if (resp_valid) begin
        t_lat = n; t_rd = resp_rdata; t_err = resp_err;
        break;
      end
      @(negedge clk);
    end
    $display("txn op=%h addr=%h wdata=%h lat=%0d ce=%0d sel=%b rdata=%h err=%b",
             op, addr, wdata, t_lat, t_ce, t_sel, t_rd, t_err);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    n_cmp++; if ({ram_ce, ram_we, resp_valid, resp_err} !== 4'b0) begin n_bad++; $display("FAIL rst_flags got %b exp 0000", {ram_ce, ram_we, resp_valid, resp_err}); end
    n_cmp++; if ({ram_addr, ram_wdata, resp_rdata, ram_sel} !== 100'd0) begin n_bad++; $display("FAIL rst_data got %h/%h/%h/%b exp 0", ram_addr, ram_wdata, resp_rdata, ram_sel); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release got ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_store_word();
    do_req(OP_SW, 32'h10, 32'hDEADBEEF);
    n_cmp++; if (t_lat != 2) begin n_bad++; $display("FAIL sw_lat got %0d exp 2", t_lat); end
    n_cmp++; if (t_ce != 1 || t_we != 1) begin n_bad++; $display("FAIL sw_wr_cycles got ce=%0d we=%0d exp 1/1", t_ce, t_we); end
    n_cmp++; if (t_sel !== 4'b1111) begin n_bad++; $display("FAIL sw_sel got %b exp 1111", t_sel); end
    n_cmp++; if (t_wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata got %h exp deadbeef", t_wd); end
    n_cmp++; if (t_ad !== 32'h10) begin n_bad++; $display("FAIL sw_addr got %h exp 00000010", t_ad); end
    n_cmp++; if (t_err !== 1'b0 || t_rd !== 32'd0) begin n_bad++; $display("FAIL sw_resp got err=%b rdata=%h exp 0/0", t_err, t_rd); end
    n_cmp++; if (!t_busy_ok) begin n_bad++; $display("FAIL sw_ready_busy got ready high exp low"); end
  endtask

  task automatic test_byte();
    do_req(OP_SB, 32'h11, 32'h000000A5);
    n_cmp++; if (t_sel !== 4'b0100) begin n_bad++; $display("FAIL sb_sel got %b exp 0100", t_sel); end
    n_cmp++; if (t_wd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sb_wdata got %h exp a5a5a5a5", t_wd); end
    n_cmp++; if (t_lat != 2) begin n_bad++; $display("FAIL sb_lat got %0d exp 2", t_lat); end
    do_req(OP_LB, 32'h11, 32'h0);
    n_cmp++; if (t_rd !== 32'hFFFFFFA5) begin n_bad++; $display("FAIL lb_data got %h exp ffffffa5", t_rd); end
    n_cmp++; if (t_lat != 4) begin n_bad++; $display("FAIL lb_lat got %0d exp 4", t_lat); end
    n_cmp++; if (t_ce != 3 || t_we != 0) begin n_bad++; $display("FAIL lb_rd_cycles got ce=%0d we=%0d exp 3/0", t_ce, t_we); end
    n_cmp++; if (!t_addr_ok || t_sel !== 4'b0100) begin n_bad++; $display("FAIL lb_addr_stable got sel=%b stable=%b exp 0100/1", t_sel, t_addr_ok); end
    do_req(OP_LBU, 32'h11, 32'h0);
    n_cmp++; if (t_rd !== 32'h000000A5) begin n_bad++; $display("FAIL lbu_data got %h exp 000000a5", t_rd); end
    n_cmp++; if (t_lat != 4) begin n_bad++; $display("FAIL lbu_lat got %0d exp 4", t_lat); end
    do_req(OP_LW, 32'h10, 32'h0);
    n_cmp++; if (t_rd !== 32'hDEA5BEEF) begin n_bad++; $display("FAIL lw_after_sb got %h exp dea5beef", t_rd); end
  endtask

  task automatic test_half();
    do_req(OP_SW, 32'h0, 32'h80017FFF);
    do_req(OP_LH, 32'h0, 32'h0);
    n_cmp++; if (t_rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh0_data got %h exp ffff8001", t_rd); end
    n_cmp++; if (t_sel !== 4'b1100) begin n_bad++; $display("FAIL lh0_sel got %b exp 1100", t_sel); end
    do_req(OP_LHU, 32'h0, 32'h0);
    n_cmp++; if (t_rd !== 32'h00008001) begin n_bad++; $display("FAIL lhu0_data got %h exp 00008001", t_rd); end
    do_req(OP_LH, 32'h2, 32'h0);
    n_cmp++; if (t_rd !== 32'h00007FFF) begin n_bad++; $display("FAIL lh2_data got %h exp 00007fff", t_rd); end
    n_cmp++; if (t_sel !== 4'b0011) begin n_bad++; $display("FAIL lh2_sel got %b exp 0011", t_sel); end
    do_req(OP_LB, 32'h3, 32'h0);
    n_cmp++; if (t_rd !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL lb3_data got %h exp ffffffff", t_rd); end
    do_req(OP_LBU, 32'h0, 32'h0);
    n_cmp++; if (t_rd !== 32'h00000080) begin n_bad++; $display("FAIL lbu0_data got %h exp 00000080", t_rd); end
    do_req(OP_SH, 32'h2, 32'h00001234);
    n_cmp++; if (t_sel !== 4'b0011 || t_wd !== 32'h12341234) begin n_bad++; $display("FAIL sh2_lanes got sel=%b wdata=%h exp 0011/12341234", t_sel, t_wd); end
    do_req(OP_LW, 32'h0, 32'h0);
    n_cmp++; if (t_rd !== 32'h80011234) begin n_bad++; $display("FAIL lw_after_sh got %h exp 80011234", t_rd); end
  endtask

  task automatic test_misaligned();
    do_req(OP_LW, 32'h13, 32'h0);
    n_cmp++; if (t_lat != 1 || t_ce != 0) begin n_bad++; $display("FAIL lw13 got lat=%0d ce=%0d exp 1/0", t_lat, t_ce); end
    n_cmp++; if (t_err !== 1'b1 || t_rd !== 32'd0) begin n_bad++; $display("FAIL lw13_resp got err=%b rdata=%h exp 1/0", t_err, t_rd); end
    do_req(OP_SH, 32'h21, 32'hFFFF);
    n_cmp++; if (t_lat != 1 || t_ce != 0) begin n_bad++; $display("FAIL sh21 got lat=%0d ce=%0d exp 1/0", t_lat, t_ce); end
    n_cmp++; if (t_err !== 1'b1 || t_rd !== 32'd0) begin n_bad++; $display("FAIL sh21_resp got err=%b rdata=%h exp 1/0", t_err, t_rd); end
    do_req(4'd3, 32'h0, 32'h0);
    n_cmp++; if (t_err !== 1'b1 || t_ce != 0 || t_lat != 1) begin n_bad++; $display("FAIL badop got err=%b ce=%0d lat=%0d exp 1/0/1", t_err, t_ce, t_lat); end
    do_req(OP_LHU, 32'h1, 32'h0);
    n_cmp++; if (t_err !== 1'b1) begin n_bad++; $display("FAIL lhu1_err got %b exp 1", t_err); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int nresp = 0;
    logic rd_ok = 1'b1;
    logic gap_ok = 1'b1;
    @(negedge clk);
    req_op = OP_LW; req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (req_ready) acc.push_back(c);
      if (resp_valid) begin
        nresp++;
        if (resp_rdata !== 32'hDEA5BEEF) rd_ok = 1'b0;
        $display("txn b2b cycle=%0d rdata=%h", c, resp_rdata);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 5) gap_ok = 1'b0;
    n_cmp++; if (acc.size() != 5) begin n_bad++; $display("FAIL b2b_accepts got %0d exp 5", acc.size()); end
    n_cmp++; if (!gap_ok) begin n_bad++; $display("FAIL b2b_spacing got uneven exp 5 cycles"); end
    n_cmp++; if (nresp != 5) begin n_bad++; $display("FAIL b2b_resps got %0d exp 5", nresp); end
    n_cmp++; if (!rd_ok) begin n_bad++; $display("FAIL b2b_rdata got wrong exp dea5beef"); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wr();
    int nresp = 0;
    @(negedge clk);
    req_valid = 1; req_op = OP_SW; req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL mid_wr_we got %b exp 1", ram_we); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ram_we !== 1'b0 || ram_ce !== 1'b0) begin n_bad++; $display("FAIL mid_wr_abort got we=%b ce=%b exp 0/0", ram_we, ram_ce); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) nresp++;
      @(negedge clk);
    end
    n_cmp++; if (nresp != 0) begin n_bad++; $display("FAIL mid_wr_resp got %0d exp 0", nresp); end
  endtask

  task automatic test_reset_mid_rd();
    int nresp = 0;
    @(negedge clk);
    req_valid = 1; req_op = OP_LW; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    n_cmp++; if (ram_ce !== 1'b1) begin n_bad++; $display("FAIL mid_rd_ce got %b exp 1", ram_ce); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ram_ce !== 1'b0 || ram_sel !== 4'b0 || ram_addr !== 32'd0) begin n_bad++; $display("FAIL mid_rd_abort got ce=%b sel=%b addr=%h exp 0", ram_ce, ram_sel, ram_addr); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rd_ready_in_rst got %b exp 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid) nresp++;
      @(negedge clk);
    end
    n_cmp++; if (nresp != 0) begin n_bad++; $display("FAIL mid_rd_resp got %0d exp 0", nresp); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rd_ready got %b exp 1", req_ready); end
    do_req(OP_LW, 32'h10, 32'h0);
    n_cmp++; if (t_rd !== 32'hDEA5BEEF || t_lat != 4) begin n_bad++; $display("FAIL post_rst_lw got %h lat=%0d exp dea5beef/4", t_rd, t_lat); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte();
    test_half();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_wr();
    test_reset_mid_rd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
